node_rx_sink: RTL and testbench



---
 rtl/node_rx_sink.sv | 197 +++++++++++++++++++
 tb/tb_node_rx_sink.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_rx_sink.sv
// node_rx_sink: receive endpoint of a mesh node's router local port (4-phase link, framing parser, payload FIFO).
// Define NODE_RX_CHECKSUM_EN to verify each tail flit against the XOR of the packet's body payloads.
module node_rx_sink #(
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] data_in,
  input  logic        req_in,
  output logic        ack_out,
  input  logic        rd_en,
  output logic [20:0] rd_data,
  output logic        empty,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count,
  output logic        pkt_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]  MY_ID   = 4'(NODE_ID);
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);
  localparam logic [1:0]  T_HEAD  = 2'b01;
  localparam logic [1:0]  T_BODY  = 2'b10;
  localparam logic [1:0]  T_TAIL  = 2'b11;

  typedef enum logic [1:0] {H_SYNC, H_WAIT, H_ACK} hs_state_t;
  typedef enum logic [1:0] {P_HEAD, P_BODY, P_TAIL, P_DROP} p_state_t;

  hs_state_t     hs_state;
  p_state_t      p_state;
  p_state_t      head_next;
  logic [17:0]   flit;
  logic          flit_valid;
  logic [1:0]    ftype;
  logic          head_match;
  logic [3:0]    src_q;
  logic [7:0]    rem;
  logic          csum_ok;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;
  logic          push;
  logic          pop;
  logic          full;
  logic [20:0]   push_data;
  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign ftype      = flit[17:16];
  assign head_match = (flit[11:8] == MY_ID);
  assign head_next  = !head_match ? P_DROP : ((flit[7:0] == 8'd0) ? P_TAIL : P_BODY);

  // A captured flit may still push next cycle, so it is counted as occupancy.
  assign full = ({1'b0, count} + {{CW{1'b0}}, flit_valid}) >= DEPTH_V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_state   <= H_SYNC;
      ack_out    <= 1'b0;
      flit       <= '0;
      flit_valid <= 1'b0;
    end else begin
      flit_valid <= 1'b0;
      case (hs_state)
        H_SYNC: begin
          ack_out <= 1'b0;
          if (!req_in) hs_state <= H_WAIT;
        end
        H_WAIT: begin
          if (req_in && !full) begin
            flit       <= data_in;
            flit_valid <= 1'b1;
            ack_out    <= 1'b1;
            hs_state   <= H_ACK;
          end
        end
        H_ACK: begin
          if (!req_in) begin
            ack_out  <= 1'b0;
            hs_state <= H_WAIT;
          end
        end
        default: begin
          ack_out  <= 1'b0;
          hs_state <= H_SYNC;
        end
      endcase
    end
  end

`ifdef NODE_RX_CHECKSUM_EN
  logic [15:0] xor_q;

  assign csum_ok = (flit[15:0] == xor_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= '0;
    end else if (flit_valid && p_state != P_DROP && ftype == T_HEAD && head_match) begin
      xor_q <= '0;
    end else if (push) begin
      xor_q <= xor_q ^ flit[15:0];
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  // An unexpected head costs one error, plus one more if it is then rejected for its destination.
  always_comb begin
    err_inc = 2'd0;
    if (flit_valid) begin
      case (p_state)
        P_HEAD: err_inc = (ftype == T_HEAD) ? {1'b0, !head_match} : 2'd1;
        P_BODY, P_TAIL: begin
          if (ftype == T_HEAD)
            err_inc = 2'd1 + {1'b0, !head_match};
          else if (p_state == P_BODY)
            err_inc = (ftype == T_BODY) ? 2'd0 : 2'd1;
          else
            err_inc = (ftype == T_TAIL) ? {1'b0, !csum_ok} : 2'd1;
        end
        default: err_inc = 2'd0;
      endcase
    end
  end

  assign push      = flit_valid && (p_state == P_BODY) && (ftype == T_BODY);
  assign push_data = {src_q, (rem == 8'd1), flit[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state   <= P_HEAD;
      src_q     <= '0;
      rem       <= '0;
      pkt_count <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (flit_valid) begin
        if (p_state == P_DROP) begin
          if (ftype == T_TAIL) p_state <= P_HEAD;
        end else if (ftype == T_HEAD) begin
          p_state <= head_next;
          if (head_match) begin
            src_q <= flit[15:12];
            rem   <= flit[7:0];
          end
        end else if (p_state == P_BODY) begin
          if (ftype == T_BODY) begin
            rem <= rem - 8'd1;
            if (rem == 8'd1) p_state <= P_TAIL;
          end else if (ftype == T_TAIL) begin
            p_state <= P_HEAD;
          end
        end else if (p_state == P_TAIL && ftype == T_TAIL) begin
          p_state <= P_HEAD;
          if (csum_ok) begin
            pkt_done  <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
          end
        end
      end
    end
  end

  assign err_sum = {1'b0, err_count} + {7'd0, err_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else     err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign empty   = (count == '0);
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_node_rx_sink.sv
// tb_node_rx_sink: directed scenarios plus randomized packet traffic for node_rx_sink,
// checked against a packet-level reference model (honours NODE_RX_CHECKSUM_EN).
`timescale 1ns/1ps
module tb_node_rx_sink;

  localparam int NODE_ID    = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int M_HEAD = 0, M_BODY = 1, M_TAIL = 2, M_DROP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] data_in;
  logic        req_in;
  logic        ack_out;
  logic        rd_en;
  logic [20:0] rd_data;
  logic        empty;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;
  logic        pkt_done;

  always #5 clk = ~clk;

  node_rx_sink #(.NODE_ID(NODE_ID), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .req_in(req_in), .ack_out(ack_out),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .pkt_count(pkt_count),
    .err_count(err_count), .pkt_done(pkt_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int donesSeen = 0;

  logic [20:0] expQ[$];
  int          mMode;
  int          mRem;
  logic [3:0]  mSrc;
  logic [15:0] mXor;
  int          expErr;
  int          expPkt;
  int          expDone = 0;

  always @(negedge clk) if (pkt_done === 1'b1) donesSeen++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    expQ.delete();
    mMode = M_HEAD; mRem = 0; mSrc = '0; mXor = '0;
    expErr = 0; expPkt = 0;
  endfunction

  function automatic void modelErr();
    if (expErr < 255) expErr++;
  endfunction

  // Packet-level view of what one accepted flit does to the node's visible state.
  function automatic void modelFlit(input logic [17:0] f);
    logic [1:0] t;
    logic       ok;
    t = f[17:16];
`ifdef NODE_RX_CHECKSUM_EN
    ok = (f[15:0] == mXor);
`else
    ok = 1'b1;
`endif
    if (mMode == M_DROP) begin
      if (t == 2'b11) mMode = M_HEAD;
      return;
    end
    if (t == 2'b01) begin
      if (mMode != M_HEAD) modelErr();
      if (f[11:8] == 4'(NODE_ID)) begin
        mSrc = f[15:12]; mRem = int'(f[7:0]); mXor = '0;
        mMode = (mRem == 0) ? M_TAIL : M_BODY;
      end else begin
        modelErr();
        mMode = M_DROP;
      end
    end else if (mMode == M_HEAD) begin
      modelErr();
    end else if (mMode == M_BODY) begin
      if (t == 2'b10) begin
        expQ.push_back({mSrc, (mRem == 1), f[15:0]});
        mXor ^= f[15:0];
        mRem--;
        if (mRem == 0) mMode = M_TAIL;
      end else begin
        modelErr();
        if (t == 2'b11) mMode = M_HEAD;
      end
    end else begin
      if (t == 2'b11) begin
        if (ok) begin expPkt = (expPkt + 1) % 65536; expDone++; end
        else modelErr();
        mMode = M_HEAD;
      end else begin
        modelErr();
      end
    end
  endfunction

  task automatic waitAck(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack_out === lvl) begin ok = 1'b1; break; end
    end
  endtask

  // One full 4-phase transfer of a flit, then the model absorbs it.
  task automatic applyStimulus(input logic [17:0] f);
    bit ok;
    @(negedge clk);
    data_in = f;
    req_in  = 1'b1;
    waitAck(1'b1, 20, ok);
    checkOutput("ack_rise", 32'(ack_out), 1);
    req_in = 1'b0;
    waitAck(1'b0, 20, ok);
    checkOutput("ack_fall", 32'(ack_out), 0);
    modelFlit(f);
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic drainFifo();
    while (expQ.size() > 0) begin
      checkOutput("fifo_not_empty", 32'(empty), 0);
      checkOutput("rd_data", 32'(rd_data), 32'(expQ[0]));
      popOne();
    end
    checkOutput("fifo_empty", 32'(empty), 1);
  endtask

  task automatic maybeDrain();
    if (expQ.size() >= FIFO_DEPTH || $urandom_range(0, 5) == 0) drainFifo();
  endtask

  task automatic checkCounters(input string tag);
    @(negedge clk);
    checkOutput({tag, "_err"}, 32'(err_count), 32'(expErr));
    checkOutput({tag, "_pkt"}, 32'(pkt_count), 32'(expPkt));
    checkOutput({tag, "_done"}, 32'(donesSeen), 32'(expDone));
  endtask

  task automatic sendPacket(input logic [3:0] src, input logic [3:0] dst, input int len,
                            input int nBodies, input bit badTail);
    logic [15:0] x;
    logic [15:0] p;
    x = '0;
    maybeDrain();
    applyStimulus({2'b01, src, dst, 8'(len)});
    for (int i = 0; i < nBodies; i++) begin
      p = 16'($urandom);
      x ^= p;
      maybeDrain();
      applyStimulus({2'b10, p});
    end
    maybeDrain();
    applyStimulus({2'b11, badTail ? (x ^ 16'($urandom_range(1, 65535))) : x});
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; req_in = 1'b0; rd_en = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    bit ok;
    bit sawAck;
    logic [3:0] dst;
    int kind;
    int len;
    rst = 1'b1; req_in = 1'b0; rd_en = 1'b0; data_in = '0;
    modelReset();
    #1;
    checkOutput("rst_ack", 32'(ack_out), 0);
    checkOutput("rst_done", 32'(pkt_done), 0);
    checkOutput("rst_pkt", 32'(pkt_count), 0);
    checkOutput("rst_err", 32'(err_count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_rd_data", 32'(rd_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reference packet");
    applyStimulus(18'h1_3502);
    applyStimulus(18'h2_1234);
    applyStimulus(18'h2_ABCD);
    applyStimulus(18'h3_B9F9);
    checkOutput("ex_first", 32'(rd_data), 32'h0006_1234);
    popOne();
    checkOutput("ex_second", 32'(rd_data), 32'h0007_ABCD);
    popOne();
    checkOutput("ex_empty", 32'(empty), 1);
    checkCounters("ex");
    checkOutput("ex_pkt_const", 32'(pkt_count), 1);
    checkOutput("ex_err_const", 32'(err_count), 0);
    checkOutput("ex_done_const", 32'(donesSeen), 1);

    $display("[TB] foreign destination");
    applyStimulus(18'h1_1703);
    applyStimulus(18'h2_0001);
    applyStimulus(18'h2_0002);
    applyStimulus(18'h2_0003);
    applyStimulus(18'h3_0000);
    checkOutput("drop_empty", 32'(empty), 1);
    checkOutput("drop_err", 32'(err_count), 1);
    sendPacket(4'd9, 4'(NODE_ID), 2, 2, 1'b0);
    drainFifo();
    checkCounters("after_drop");

    $display("[TB] short packet");
    applyStimulus(18'h1_4503);
    applyStimulus(18'h2_7777);
    applyStimulus(18'h3_7777);
    checkOutput("short_err", 32'(err_count), 2);
    checkOutput("short_pkt", 32'(pkt_count), 2);
    drainFifo();
    sendPacket(4'd1, 4'(NODE_ID), 1, 1, 1'b0);
    drainFifo();
    checkCounters("after_short");

    $display("[TB] FIFO back-pressure");
    applyStimulus(18'h1_2506);
    for (int i = 0; i < 4; i++) applyStimulus({2'b10, 16'h1000 + 16'(i)});
    @(negedge clk);
    data_in = {2'b10, 16'h1004};
    req_in = 1'b1;
    sawAck = 1'b0;
    repeat (4) begin @(negedge clk); if (ack_out) sawAck = 1'b1; end
    checkOutput("stall_ack_low", 32'(sawAck), 0);
    checkOutput("stall_rd_data", 32'(rd_data), 32'(expQ[0]));
    popOne();
    waitAck(1'b1, 2, ok);
    checkOutput("stall_release", 32'(ack_out), 1);
    req_in = 1'b0;
    waitAck(1'b0, 20, ok);
    checkOutput("stall_ack_fall", 32'(ack_out), 0);
    modelFlit({2'b10, 16'h1004});
    drainFifo();
    applyStimulus({2'b10, 16'h1005});
    applyStimulus({2'b11, 16'h1001});
    drainFifo();
    checkCounters("stall");

    $display("[TB] reset during handshake");
    applyStimulus(18'h1_3502);
    applyStimulus(18'h2_5555);
    @(negedge clk);
    data_in = 18'h2_6666;
    req_in = 1'b1;
    waitAck(1'b1, 20, ok);
    checkOutput("mid_ack_high", 32'(ack_out), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ack", 32'(ack_out), 0);
    checkOutput("mid_rst_empty", 32'(empty), 1);
    checkOutput("mid_rst_pkt", 32'(pkt_count), 0);
    checkOutput("mid_rst_err", 32'(err_count), 0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sawAck = 1'b0;
    repeat (4) begin @(negedge clk); if (ack_out) sawAck = 1'b1; end
    checkOutput("mid_no_recapture", 32'(sawAck), 0);
    req_in = 1'b0;
    sendPacket(4'd3, 4'(NODE_ID), 2, 2, 1'b0);
    drainFifo();
    checkCounters("mid_rst");

    $display("[TB] error saturation");
    resetDut();
    for (int i = 0; i < 256; i++) applyStimulus({2'b00, 16'($urandom)});
    checkCounters("sat");
    checkOutput("sat_err_const", 32'(err_count), 255);
    checkOutput("sat_pkt_const", 32'(pkt_count), 0);

    $display("[TB] randomized traffic");
    resetDut();
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1, 2: begin
          len = $urandom_range(0, 3);
          sendPacket(4'($urandom), 4'(NODE_ID), len, len, 1'b0);
        end
        3: begin
          dst = 4'($urandom);
          if (dst == 4'(NODE_ID)) dst = dst + 4'd1;
          len = $urandom_range(0, 3);
          sendPacket(4'($urandom), dst, len, len, 1'b0);
        end
        4: begin
          len = $urandom_range(2, 3);
          sendPacket(4'($urandom), 4'(NODE_ID), len, len - 1, 1'b0);
        end
        5: begin
          len = $urandom_range(0, 2);
          sendPacket(4'($urandom), 4'(NODE_ID), len, len + 1, 1'b0);
        end
        6: begin
          maybeDrain();
          applyStimulus(18'($urandom));
        end
        default: begin
          len = $urandom_range(1, 3);
          sendPacket(4'($urandom), 4'(NODE_ID), len, len, 1'b1);
        end
      endcase
      if (it % 10 == 9) begin
        drainFifo();
        checkCounters("rand");
      end
    end
    drainFifo();
    checkCounters("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
